// File: rtl/key_schedule.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : key_schedule                                                  |
// | Description: Sequential AES-128 key expansion, one round key per clock,    |
// |              with an 11-entry round-key table and a registered read port.  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module key_schedule #(
   parameter int NR = 10,
   parameter int KW = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [KW-1:0] key_in,
   output logic          busy,
   output logic          done,
   output logic          keys_valid,
   input  logic [3:0]    rk_addr,
   output logic [KW-1:0] rk_out
);

   localparam logic [3:0] c_LAST_RND = 4'(NR);
   localparam logic [3:0] c_MAX_ADDR = 4'd10;

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_EXPAND = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [3:0]      r_rnd;
   logic [KW-1:0]   r_cur;
   logic [KW-1:0]   w_nxt;
   logic [KW-1:0]   w_rd;
   logic [KW-1:0]   r_rk [0:10];
   logic            r_busy;
   logic            r_done;
   logic            r_keys_valid;
   logic [KW-1:0]   r_rk_out;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box built from the field inverse (x^254) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] s;
      r = 8'h01;
      s = x;
      for (int k = 0; k < 7; k++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
             {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] rcon(input logic [7:0] i);
      logic [7:0] rc;
      case (i)
         8'd1:    rc = 8'h01;
         8'd2:    rc = 8'h02;
         8'd3:    rc = 8'h04;
         8'd4:    rc = 8'h08;
         8'd5:    rc = 8'h10;
         8'd6:    rc = 8'h20;
         8'd7:    rc = 8'h40;
         8'd8:    rc = 8'h80;
         8'd9:    rc = 8'h1b;
         8'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   function automatic logic [127:0] ke_core(input logic [127:0] word_in, input logic [7:0] i);
      logic [31:0] t;
      logic [31:0] w4;
      logic [31:0] w5;
      logic [31:0] w6;
      logic [31:0] w7;
      t  = {sbox(word_in[23:16]), sbox(word_in[15:8]), sbox(word_in[7:0]),
            sbox(word_in[31:24])} ^ {rcon(i), 24'h000000};
      w4 = word_in[127:96] ^ t;
      w5 = word_in[95:64]  ^ w4;
      w6 = word_in[63:32]  ^ w5;
      w7 = word_in[31:0]   ^ w6;
      return {w4, w5, w6, w7};
   endfunction

   assign w_nxt = ke_core(r_cur, {4'b0000, r_rnd});
   assign w_rd  = (rk_addr <= c_MAX_ADDR) ? r_rk[rk_addr] : '0;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (start) w_state_nxt = S_EXPAND;
         S_EXPAND: if (r_rnd == c_LAST_RND) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_rnd        <= 4'd0;
         r_cur        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_keys_valid <= 1'b0;
         r_rk_out     <= '0;
         for (int i = 0; i <= 10; i++) r_rk[i] <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_done   <= 1'b0;
         // Non-blocking read: a same-edge write to this entry is seen one edge later
         r_rk_out <= w_rd;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_rk[0]      <= key_in;
                  r_cur        <= key_in;
                  r_rnd        <= 4'd1;
                  r_keys_valid <= 1'b0;
                  r_busy       <= 1'b1;
               end
            end
            S_EXPAND: begin
               r_rk[r_rnd] <= w_nxt;
               r_cur       <= w_nxt;
               if (r_rnd == c_LAST_RND) begin
                  r_rnd        <= 4'd0;
                  r_busy       <= 1'b0;
                  r_done       <= 1'b1;
                  r_keys_valid <= 1'b1;
               end else begin
                  r_rnd <= r_rnd + 4'd1;
               end
            end
            default: r_rnd <= 4'd0;
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign keys_valid = r_keys_valid;
   assign rk_out     = r_rk_out;

endmodule
`default_nettype wire

// File: tb/tb_key_schedule.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_key_schedule                                               |
// | Description: Scoreboard bench for key_schedule against a FIPS-197 model.   |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_key_schedule;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] key_in;
   logic         busy;
   logic         done;
   logic         keys_valid;
   logic [3:0]   rk_addr;
   logic [127:0] rk_out;

   key_schedule #(.NR(10), .KW(128)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .key_in     (key_in),
      .busy       (busy),
      .done       (done),
      .keys_valid (keys_valid),
      .rk_addr    (rk_addr),
      .rk_out     (rk_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         c;
      logic [3:0] a;
      logic [127:0] d;
   } rd_t;

   int           tests = 0;
   int           fails = 0;
   int           cyc   = 0;
   rd_t          rd_q[$];
   int           done_q[$];
   bit           abort_busy = 1'b0;
   int           bcnt = 0;
   logic [7:0]   sb [256];
   logic [127:0] model_rk [11];
   logic [127:0] old_rk [11];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // S-box from log/antilog tables over generator 3
   function automatic void build_sbox();
      logic [7:0] alog [256];
      int         lg [256];
      logic [7:0] p;
      logic [7:0] inv;
      logic [7:0] s;
      p = 8'h01;
      for (int i = 0; i < 255; i++) begin
         alog[i] = p;
         lg[p]   = i;
         p       = p ^ xt(p);
      end
      for (int x = 0; x < 256; x++) begin
         inv = (x == 0) ? 8'h00 : alog[(255 - lg[x]) % 255];
         s   = 8'h63;
         for (int b = 0; b < 8; b++)
            s[b] = s[b] ^ inv[b] ^ inv[(b + 4) % 8] ^ inv[(b + 5) % 8] ^
                   inv[(b + 6) % 8] ^ inv[(b + 7) % 8];
         sb[x] = s;
      end
   endfunction

   function automatic void compute_model(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i - 1];
         if (i % 4 == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i - 4] ^ t;
      end
      for (int r = 0; r < 11; r++)
         model_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
   endfunction

   // Monitor: read responses, done pulses and busy run length
   always @(negedge clk) begin
      rd_t r;
      int  e;
      while (rd_q.size() > 0 && rd_q[0].c == cyc - 1) begin
         r = rd_q.pop_front();
         check($sformatf("rk_out[%0d]", r.a), rk_out, r.d);
      end
      if (done === 1'b1) begin
         if (done_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
         end else begin
            e = done_q.pop_front();
            check("done_cycle", 128'(cyc), 128'(e));
            check("keys_valid_at_done", {127'd0, keys_valid}, 128'd1);
         end
      end
      if (busy === 1'b1) begin
         bcnt++;
      end else begin
         if (bcnt != 0 && !abort_busy) check("busy_length", 128'(bcnt), 128'd10);
         bcnt       = 0;
         abort_busy = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_exp(input logic [127:0] k);
      start  = 1'b1;
      key_in = k;
      tick();
      start  = 1'b0;
      key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      done_q.push_back(cyc + 10);
      compute_model(k);
   endtask

   task automatic expect_rd(input logic [3:0] a, input logic [127:0] d);
      rk_addr = a;
      rd_q.push_back('{cyc, a, d});
      tick();
   endtask

   task automatic sweep();
      for (int a = 0; a < 16; a++)
         expect_rd(a[3:0], (a <= 10) ? model_rk[a] : 128'd0);
      tick();
   endtask

   initial begin
      logic [127:0] k;
      build_sbox();
      rst     = 1'b1;
      start   = 1'b0;
      key_in  = '0;
      rk_addr = 4'd0;
      tick();
      tick();
      check("reset_busy", {127'd0, busy}, 128'd0);
      check("reset_done", {127'd0, done}, 128'd0);
      check("reset_keys_valid", {127'd0, keys_valid}, 128'd0);
      check("reset_rk_out", rk_out, 128'd0);
      rst = 1'b0;
      tick();

      // FIPS-197 key, with an ignored start at T+3
      start_exp(128'h2b7e151628aed2a6abf7158809cf4f3c);
      tick();
      tick();
      start  = 1'b1;
      key_in = 128'h000102030405060708090a0b0c0d0e0f;
      tick();
      start  = 1'b0;
      repeat (7) tick();
      sweep();
      expect_rd(4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c);
      expect_rd(4'd1,  128'ha0fafe1788542cb123a339392a6c7605);
      expect_rd(4'd2,  128'hf2c295f27a96b9435935807a7359f67f);
      expect_rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      tick();

      // start held high: re-accepted in the done cycle
      start  = 1'b1;
      key_in = 128'h000102030405060708090a0b0c0d0e0f;
      tick();
      done_q.push_back(cyc + 10);
      done_q.push_back(cyc + 21);
      compute_model(key_in);
      repeat (11) tick();
      start = 1'b0;
      check("kv_low_after_reaccept", {127'd0, keys_valid}, 128'd0);
      check("busy_after_reaccept", {127'd0, busy}, 128'd1);
      repeat (11) tick();
      check("kv_high_after_second", {127'd0, keys_valid}, 128'd1);
      sweep();
      expect_rd(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
      tick();

      // Read/write collisions return the old entry
      old_rk = model_rk;
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      rk_addr = 4'd0;
      start   = 1'b1;
      key_in  = k;
      rd_q.push_back('{cyc, 4'd0, old_rk[0]});
      tick();
      start = 1'b0;
      done_q.push_back(cyc + 10);
      compute_model(k);
      expect_rd(4'd0, model_rk[0]);
      expect_rd(4'd2, old_rk[2]);
      expect_rd(4'd2, model_rk[2]);
      repeat (8) tick();
      sweep();

      // Reset mid-expansion aborts with no done pulse
      start_exp({$urandom(), $urandom(), $urandom(), $urandom()});
      repeat (4) tick();
      abort_busy = 1'b1;
      rst        = 1'b1;
      done_q.delete();
      tick();
      rst = 1'b0;
      check("abort_busy", {127'd0, busy}, 128'd0);
      check("abort_keys_valid", {127'd0, keys_valid}, 128'd0);
      check("abort_done", {127'd0, done}, 128'd0);
      check("abort_rk_out", rk_out, 128'd0);
      for (int i = 0; i < 11; i++) model_rk[i] = '0;
      sweep();
      repeat (6) tick();

      // All-zero key after the abort
      start_exp(128'd0);
      repeat (10) tick();
      sweep();
      expect_rd(4'd1,  128'h62636363626363636263636362636363);
      expect_rd(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
      tick();

      // Random keys against the model
      for (int n = 0; n < 8; n++) begin
         start_exp({$urandom(), $urandom(), $urandom(), $urandom()});
         repeat (10) tick();
         sweep();
         for (int j = 0; j < 4; j++) begin
            k[3:0] = 4'($urandom_range(0, 15));
            expect_rd(k[3:0], (k[3:0] <= 4'd10) ? model_rk[k[3:0]] : 128'd0);
         end
         tick();
      end

      repeat (3) tick();
      if (done_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL missing_done: got %0d outstanding expected 0", done_q.size());
      end
      if (rd_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL missing_read: got %0d outstanding expected 0", rd_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/key_schedule.md
Name: key_schedule

Overview:
Sequential AES-128 key-expansion controller that iterates the combinational ke_core round function once per clock. It produces round keys 1..10 from the cipher key and stores all 11 round keys in an internal register file. It sits between the host key-load interface and the cipher round datapath, which fetches round keys through a registered read port.

Parameters:
NR, 10, number of expansion rounds; only 10 (AES-128) is supported, and other values are out of scope.
KW, 128, key and round-key width in bits; fixed at 128.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request expansion of key_in; sampled only in IDLE
key_in  input  128  cipher key; bits [127:96] = W0, [31:0] = W3 (FIPS-197 byte order, MSB first)
busy  output  1  expansion in progress
done  output  1  one-cycle pulse: table complete
keys_valid  output  1  level: all 11 round keys valid
rk_addr  input  4  round-key index 0..10
rk_out  output  128  registered round key at rk_addr

Behaviour:
- One clock, clk; reset rst is synchronous and active-high. While rst=1 at an edge: state<=IDLE, round counter<=0, busy=0, done=0, keys_valid=0, rk_out=0, and all 11 table entries <=0. Reset mid-expansion aborts immediately; no partial keys are kept as valid.
- States: IDLE, EXPAND.
- IDLE with start=1 at edge T:
  - rk[0]<=key_in; working reg cur<=key_in; rnd<=1; keys_valid<=0; busy<=1; state<=EXPAND.
  - key_in is sampled only at edge T and may change afterwards.
- EXPAND, each edge:
  - nxt = ke_core(word_in=cur, i={4'b0,rnd}); rk[rnd]<=nxt; cur<=nxt; rnd<=rnd+1.
  - The rcon lookup inside ke_core is indexed by round number 1..10 (01,02,04,08,10,20,40,80,1b,36).
- At the edge where rnd==NR (edge T+10), after writing rk[10]: state<=IDLE, busy<=0, done<=1 for exactly one cycle, keys_valid<=1.
- Latency: start sampled at T -> done and keys_valid high after edge T+10. Total is 10 cycles of busy.
- start while busy=1: ignored, no effect on the running expansion.
- start=1 in the same cycle that done=1: state is IDLE, so it is accepted. This begins a new expansion; keys_valid drops after that edge.
- keys_valid stays high until the next accepted start or rst.
- Read port: rk_out<=rk[rk_addr] on every edge, giving 1-cycle read latency.
  - rk_addr 11..15 -> rk_out<=0.
  - Reads during EXPAND return current table contents. These may be a mix of old and new keys, and consumers must gate on keys_valid.
- Read/write collision (rk_addr equals the entry written that edge): rk_out returns the old value. The new value is visible from the next edge.
- The round counter is 4 bits and never wraps; it is held at 0 in IDLE.
- No combinational path from any input to any output.

Test Plan:
- Reset then FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start for 1 cycle -> busy high for 10 cycles, done a single pulse at T+10. rk[0]=2b7e1516...4f3c, rk[1]=a0fafe1788542cb123a339392a6c7605, rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Read sweep after done, rk_addr=0..15 -> each rk_out appears 1 cycle after its address. rk[2]=f2c295f27a96b9435935807a7359f67f; addr 11..15 -> 0.
- Pulse start again at T+3 with key 000102030405060708090a0b0c0d0e0f -> ignored. Results still match the first key; done is still at T+10.
- Hold start=1 continuously with key 000102...0f -> re-accepted in the done cycle, keys_valid toggles low the next cycle, rk[10]=13111d7fe3944a17f307a78b4d2b30c5.
- Assert rst at T+5 mid-expansion -> next cycle busy=0, keys_valid=0, rk_out=0 for all addresses, no done pulse. A fresh start then completes normally.
- All-zero key -> rk[1]=62636363626363636263636362636363, rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
